cdr_tx: RTL and testbench

- 4x-oversampled serial transmitter. It is the sending end of the 40 MHz-sampled, 10 Mb/s NRZ link whose receiving end recovers clock and data with an oversampling state machine.
- Accepts bytes over a valid/ready handshake and drives a single line, `dout`.
- Line idles high; frames are a sync pattern followed by back-to-back payload bytes, MSB first.
- Every bit lasts exactly OVS clocks, giving the receiver clean 4-sample cells.

---
 rtl/cdr_tx.sv | 141 ++++++++++++++
 tb/tb_cdr_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_tx.sv
// cdr_tx: 4x-oversampled NRZ serial transmitter.
// Bytes arrive over a valid/ready handshake. Each frame on the idle-high
// line is a sync pattern followed by back-to-back payload bytes, MSB first.
// Every bit is held for exactly OVS clocks.
module cdr_tx #(
    parameter int          OVS       = 4,
    parameter int          IDLE_BITS = 16,
    parameter int          SYNC_BITS = 8,
    parameter logic [15:0] SYNC_PAT  = 16'h0055,
    parameter int          GAP_BITS  = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       dout,
    output logic       tx_busy
);

    localparam int DIV_W = (OVS > 2) ? $clog2(OVS) : 1;
    // Sync pattern moved to the top of a 16-bit word so it shifts out MSB first
    localparam logic [15:0] SYNC_ALIGNED = SYNC_PAT << (16 - SYNC_BITS);

    typedef enum logic [2:0] {
        WARM = 3'd0,
        IDLE = 3'd1,
        SYNC = 3'd2,
        DATA = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [15:0]      cnt;       // warm-up / gap periods, or bits left after the current one
    logic [15:0]      shreg;     // next bits to send, MSB first
    logic [7:0]       data_reg;  // byte waiting behind the sync pattern
    logic             bit_end;
    logic             accept;

    assign bit_end  = (div == DIV_W'(OVS - 1));
    assign tx_ready = bit_end && ((state == IDLE) || ((state == DATA) && (cnt == 16'd0)));
    assign accept   = tx_valid && tx_ready;
    assign tx_busy  = (state != IDLE);

    // Free-running bit timer; every bit boundary follows a bit_end cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div <= '0;
        end else if (bit_end) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Frame sequencer with registered line output
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= WARM;
            cnt      <= '0;
            shreg    <= '0;
            data_reg <= '0;
            dout     <= 1'b1;
        end else begin
            case (state)
                WARM: begin
                    dout <= 1'b1;
                    if (bit_end) begin
                        if (cnt == 16'(IDLE_BITS - 1)) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                IDLE: begin
                    dout <= 1'b1;
                    if (accept) begin
                        data_reg <= tx_data;
                        dout     <= SYNC_ALIGNED[15];
                        shreg    <= SYNC_ALIGNED << 1;
                        cnt      <= 16'(SYNC_BITS - 1);
                        state    <= SYNC;
                    end
                end
                SYNC: begin
                    if (bit_end) begin
                        if (cnt == 16'd0) begin
                            // Last sync bit done: payload follows with no gap
                            dout  <= data_reg[7];
                            shreg <= {data_reg[6:0], 9'd0};
                            cnt   <= 16'd7;
                            state <= DATA;
                        end else begin
                            dout  <= shreg[15];
                            shreg <= shreg << 1;
                            cnt   <= cnt - 16'd1;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (cnt != 16'd0) begin
                            dout  <= shreg[15];
                            shreg <= shreg << 1;
                            cnt   <= cnt - 16'd1;
                        end else if (accept) begin
                            // Chained byte: continue the frame without a new sync
                            data_reg <= tx_data;
                            dout     <= tx_data[7];
                            shreg    <= {tx_data[6:0], 9'd0};
                            cnt      <= 16'd7;
                        end else begin
                            dout  <= 1'b1;
                            cnt   <= 16'(GAP_BITS - 1);
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    dout <= 1'b1;
                    if (bit_end) begin
                        if (cnt == 16'd0) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                end
                default: begin
                    state <= WARM;
                    cnt   <= '0;
                    dout  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdr_tx.sv
// tb_cdr_tx: directed bench for cdr_tx with a cell-level line model and a
// simple 4x-oversampling loopback receiver.
module tb_cdr_tx;

    localparam int          OVS       = 4;
    localparam int          IDLE_BITS = 16;
    localparam int          SYNC_BITS = 8;
    localparam logic [15:0] SYNC_PAT  = 16'h0055;
    localparam int          GAP_BITS  = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       dout;
    logic       tx_busy;

    cdr_tx #(
        .OVS(OVS), .IDLE_BITS(IDLE_BITS), .SYNC_BITS(SYNC_BITS),
        .SYNC_PAT(SYNC_PAT), .GAP_BITS(GAP_BITS)
    ) dut (
        .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .dout(dout), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Line model: each cell (bit period) of the line since reset release
    int   cyc;
    int   idle_from;
    bit   frame_active;
    int   frame_end;
    bit   cells[int];
    logic hist_d[int];
    logic hist_b[int];
    int   acc_log[$];

    always @(negedge clk) begin
        int   k;
        bit   be;
        logic e_ready, e_busy, e_dout;
        if (!rstn) begin
            check("reset_dout", dout, 1'b1);
            check("reset_ready", tx_ready, 1'b0);
            check("reset_busy", tx_busy, 1'b1);
            cyc = 0;
            idle_from = IDLE_BITS;
            frame_active = 0;
            frame_end = 0;
            cells.delete();
            hist_d.delete();
            hist_b.delete();
        end else begin
            k = cyc / OVS;
            be = (cyc % OVS) == (OVS - 1);
            e_ready = be && ((!frame_active && k >= idle_from) || (frame_active && k == frame_end));
            e_busy  = frame_active || (k < idle_from);
            e_dout  = cells.exists(k) ? cells[k] : 1'b1;
            check($sformatf("dout@%0d", cyc), dout, e_dout);
            check($sformatf("tx_ready@%0d", cyc), tx_ready, e_ready);
            check($sformatf("tx_busy@%0d", cyc), tx_busy, e_busy);
            hist_d[cyc] = dout;
            hist_b[cyc] = tx_busy;
            if (tx_ready && tx_valid) acc_log.push_back(cyc);
            if (e_ready) begin
                if (tx_valid) begin
                    if (!frame_active) begin
                        for (int j = 0; j < SYNC_BITS; j++) cells[k + 1 + j] = SYNC_PAT[SYNC_BITS - 1 - j];
                        frame_end = k + SYNC_BITS;
                        frame_active = 1;
                    end
                    for (int j = 0; j < 8; j++) cells[frame_end + 1 + j] = tx_data[7 - j];
                    frame_end += 8;
                end else if (frame_active) begin
                    frame_active = 0;
                    idle_from = frame_end + GAP_BITS + 1;
                end
            end
            cyc++;
        end
    end

    // Loopback receiver: lock on the first falling edge, re-phase on every
    // transition, sample each cell in its middle
    bit   rx_en = 0;
    bit   rx_locked;
    logic rx_prev;
    int   rx_phase;
    logic rq[$];

    always @(negedge clk) begin
        if (!rx_en) begin
            rx_locked = 0;
            rx_prev = dout;
            rx_phase = 0;
        end else begin
            if (!rx_locked) begin
                if (rx_prev && !dout) begin
                    rx_locked = 1;
                    rx_phase = 0;
                end
            end else begin
                rx_phase = (dout != rx_prev) ? 0 : (rx_phase + 1) % OVS;
            end
            if (rx_locked && rx_phase == OVS / 2) rq.push_back(dout);
            rx_prev = dout;
        end
    end

    task automatic wait_accept(input string name, output int acc);
        int n0 = acc_log.size();
        acc = -1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (acc_log.size() > n0) begin
                acc = acc_log[n0];
                #1;
                return;
            end
        end
        check({name, "_timeout"}, 0, 1);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (!tx_busy) begin
                repeat (4) @(posedge clk);
                #1;
                return;
            end
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    task automatic line_vec(input int start, input int ncells, output logic [31:0] vec, output logic wide_ok);
        vec = '0;
        wide_ok = 1'b1;
        for (int j = 0; j < ncells; j++) begin
            vec[ncells - 1 - j] = hist_d[start + OVS * j];
            for (int s = 1; s < OVS; s++)
                if (hist_d[start + OVS * j + s] !== hist_d[start + OVS * j]) wide_ok = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int a, a1, a2, a3, fall, n0;
        logic [31:0] vec;
        logic wide_ok;
        logic [7:0] b;

        // Reset, release with a byte already pending
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        wait_accept("first_accept", a);
        check("first_accept_cycle", a, 67);
        tx_valid = 1'b0;
        wait_idle("frame_a5");
        line_vec(a + 1, 20, vec, wide_ok);
        check("frame_a5_cells", vec, 32'h55A5F);
        check("frame_a5_cell_width", wide_ok, 1'b1);
        fall = -1;
        for (int c = a + 1; c < a + 400; c++)
            if (fall < 0 && hist_b.exists(c) && hist_b[c] == 1'b0) fall = c;
        check("frame_a5_busy_fall", fall, 148);

        // Back-to-back bytes 00, FF
        tx_valid = 1'b1;
        tx_data = 8'h00;
        wait_accept("b2b_first", a1);
        tx_data = 8'hFF;
        wait_accept("b2b_second", a2);
        tx_valid = 1'b0;
        check("b2b_accept_spacing", a2 - a1, (SYNC_BITS + 8) * OVS);
        wait_idle("b2b");
        line_vec(a1 + 1, 28, vec, wide_ok);
        check("b2b_cells", vec, 32'h5500FFF);
        check("b2b_cell_width", wide_ok, 1'b1);

        // Valid pulse between bit_ends in IDLE is not accepted
        for (int i = 0; i < 8; i++) begin
            if (cyc % OVS != 0) begin
                @(posedge clk);
                #1;
            end
        end
        n0 = acc_log.size();
        tx_valid = 1'b1;
        tx_data = 8'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pulse_no_accept", acc_log.size(), n0);
        check("pulse_busy", tx_busy, 1'b0);
        check("pulse_dout", dout, 1'b1);

        // Reset during the 3rd payload bit
        tx_valid = 1'b1;
        tx_data = 8'h5A;
        wait_accept("pre_reset", a);
        tx_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cyc != a + 1 + (SYNC_BITS + 2) * OVS + 1) begin
                @(posedge clk);
                #1;
            end
        end
        check("pre_reset_dout", dout, 1'b0);
        rstn = 1'b0;
        #1;
        check("async_reset_dout", dout, 1'b1);
        check("async_reset_busy", tx_busy, 1'b1);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hC3;
        wait_accept("rewarm", a);
        check("rewarm_accept_cycle", a, 67);
        tx_valid = 1'b0;
        wait_idle("rewarm_frame");

        // Loopback of three chained bytes through the receiver
        rq.delete();
        rx_en = 1;
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data = 8'h3C;
        wait_accept("loop_1", a1);
        tx_data = 8'hC3;
        wait_accept("loop_2", a2);
        tx_data = 8'h81;
        wait_accept("loop_3", a3);
        tx_valid = 1'b0;
        wait_idle("loop");
        rx_en = 0;
        check("loop_rcv_pulses", rq.size() >= 32, 1'b1);
        for (int by = 0; by < 4; by++) begin
            for (int j = 0; j < 8; j++) b[7 - j] = (by * 8 + j < rq.size()) ? rq[by * 8 + j] : 1'bx;
            case (by)
                0: check("loop_sync", b, 8'h55);
                1: check("loop_byte0", b, 8'h3C);
                2: check("loop_byte1", b, 8'hC3);
                default: check("loop_byte2", b, 8'h81);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
